factorial_unit: RTL and testbench
=================================

# factorial_unit

Sequential factorial engine that computes R = D_in! by repeated multiply-and-decrement. It is built from a control FSM (factorial_ctrlpath) and a datapath (factorial_datapath) joined inside this wrapper. Software or a parent FSM drives Start and an 8-bit operand, then waits for Stop and reads the 17-bit result. It is a standalone arithmetic helper with no bus interface.

## Interface
- No parameters; widths are fixed (operand 8 bits, result 17 bits, state 2 bits).
- One clock; reset is asynchronous and active-low.
- Clk  input  1  rising-edge clock for all registers.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  level request: begin a computation when sampled high in IDLE.
- D_in  input  8  operand N; sampled only in LOAD.
- Stop  output  1  high while in DONE; result valid.
- R  output  17  result register (datapath Rw).
- N  output  8  down-counter register (datapath Nw), for debug and visibility.
- State  output  2  current FSM state encoding.

## Operation
- Internal control signals run ctrlpath to datapath:
  - LdN: load N from D_in.
  - Clr: set R to 1.
  - LdR: R <= R*N.
  - DecN: N <= N-1.
- Status signal CN runs datapath to ctrlpath: CN = (N == 0), combinational.
- FSM states and behaviour:
  - IDLE (00): no register updates. If Start=1, go to LOAD; otherwise stay.
  - LOAD (01): assert LdN and Clr. N <= D_in, R <= 1. Unconditionally go to MULT.
  - MULT (10): if CN=0, assert LdR and DecN: R <= R*N (low 17 bits of the 25-bit product) and N <= N-1, then stay in MULT. If CN=1, no update; go to DONE.
  - DONE (11): Stop=1; R and N hold. Stay while Start=1; go to IDLE when Start=0.
- Stop is decoded combinationally from State (State==DONE); it is glitch-free because State is registered.
- Arithmetic: each product is truncated to 17 bits, so the final R = D_in! mod 2^17. Results are exact for D_in ≤ 8 (8! = 40320). No overflow flag.
- D_in = 0 yields R = 1 (0! = 1). N never decrements below 0.
- Changes on D_in outside LOAD are ignored.
- A Start pulse shorter than one cycle that misses the IDLE sampling edge is ignored.

## Timing
- Reset (Rst_n=0, asynchronous): State=IDLE, N=0, R=0, Stop=0, immediately and regardless of Clk. Release is synchronous to the next rising edge.
- Reset mid-computation aborts the computation; the next run requires a fresh Start in IDLE.
- Let edge e0 be the edge at which IDLE samples Start=1:
  - e0: State becomes LOAD.
  - e1: N=D_in, R=1, State becomes MULT.
  - e2 .. e(D_in+1): one multiply/decrement per edge.
  - e(D_in+2): State becomes DONE, Stop rises.
- Latency from the Start-sampling edge to Stop is D_in+2 edges (10 for D_in=8; 2 for D_in=0).
- Stop stays high until the first edge at which Start is sampled 0 in DONE. The FSM is then in IDLE and can accept a new Start on the following edge.
- Holding Start high permanently gives exactly one computation; there is no auto-restart.

## Test plan
- Rst_n low, then Start=1, D_in=8 -> R sequence after LOAD: 1, 8, 56, 336, 1680, 6720, 20160, 40320, 40320. N counts 8 down to 0. Stop rises at e10 with R=40320 and then holds.
- D_in=0 -> one cycle in MULT, Stop at e2, R=1, N=0. D_in=1 -> Stop at e3, R=1.
- D_in=5 -> R=120 at Stop (e7). Change D_in to 3 during MULT -> result unchanged.
- D_in=9 -> R = 362880 mod 131072 = 100736 at Stop (e11), showing truncation.
- Drop Start in DONE -> State=IDLE next edge, Stop=0. Then Start=1, D_in=4 -> R=24, and the stale R is not reused.
- Assert Rst_n low mid-MULT between clock edges -> State, N and R clear to 0/IDLE immediately, and Stop stays low.

Source files
------------

// File: rtl/factorial_unit.sv
// factorial_unit: multiply-and-decrement factorial engine.
// Control FSM and datapath joined under one wrapper.
package factorial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    MULT = 2'b10,
    DONE = 2'b11
  } state_t;

  typedef struct packed {
    logic ld_n;
    logic clr;
    logic ld_r;
    logic dec_n;
  } ctrl_t;

endpackage

module factorial_ctrlpath
  import factorial_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  logic   cn,
  output ctrl_t  ctrl,
  output state_t state,
  output logic   stop
);

  state_t state_q;
  state_t state_d;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and datapath strobes
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        ctrl.ld_n = 1'b1;
        ctrl.clr  = 1'b1;
        state_d   = MULT;
      end
      MULT: begin
        if (cn) begin
          state_d = DONE;
        end else begin
          ctrl.ld_r  = 1'b1;
          ctrl.dec_n = 1'b1;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state = state_q;
  assign stop  = (state_q == DONE);

endmodule

module factorial_datapath
  import factorial_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  d_in,
  input  ctrl_t       ctrl,
  output logic [16:0] r,
  output logic [7:0]  n,
  output logic        cn
);

  logic [16:0] prod;

  // product kept to the result width; upper bits are
  // deliberately dropped (result is N! mod 2^17)
  assign prod = r * {9'd0, n};
  assign cn   = (n == 8'd0);

  // down-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 8'd0;
    end else if (ctrl.ld_n) begin
      n <= d_in;
    end else if (ctrl.dec_n && !cn) begin
      n <= n - 8'd1;
    end
  end

  // result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= 17'd0;
    end else if (ctrl.clr) begin
      r <= 17'd1;
    end else if (ctrl.ld_r) begin
      r <= prod;
    end
  end

endmodule

module factorial_unit
  import factorial_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [7:0]  D_in,
  output logic        Stop,
  output logic [16:0] R,
  output logic [7:0]  N,
  output logic [1:0]  State
);

  ctrl_t  ctrl;
  state_t state;
  logic   cn;

  factorial_ctrlpath u_ctrl (
    .clk   (Clk),
    .rst_n (Rst_n),
    .start (Start),
    .cn    (cn),
    .ctrl  (ctrl),
    .state (state),
    .stop  (Stop)
  );

  factorial_datapath u_dp (
    .clk   (Clk),
    .rst_n (Rst_n),
    .d_in  (D_in),
    .ctrl  (ctrl),
    .r     (R),
    .n     (N),
    .cn    (cn)
  );

  assign State = state;

endmodule

// File: tb/tb_factorial_unit.sv
// tb_factorial_unit: random and directed runs of
// factorial_unit against an arithmetic model.
module tb_factorial_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [7:0]  D_in;
  logic        Stop;
  logic [16:0] R;
  logic [7:0]  N;
  logic [1:0]  State;

  int checks = 0;
  int errors = 0;

  factorial_unit dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .D_in  (D_in),
    .Stop  (Stop),
    .R     (R),
    .N     (N),
    .State (State)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  // d*(d-1)*...*(d-j+1) reduced mod 2^17
  function automatic longint falling(input int d, input int j);
    longint p = 1;
    for (int i = 0; i < j; i++) p = p * (d - i);
    return p % 131072;
  endfunction

  // one full computation from IDLE back to IDLE
  task automatic run(input int d, input bit wiggle);
    int edges;
    int j;
    Start = 1'b1;
    D_in  = 8'(d);
    @(posedge Clk); #1;
    check("e0_state", State, 1);
    @(posedge Clk); #1;
    edges = 1;
    check("e1_n", N, d);
    check("e1_r", R, 1);
    check("e1_state", State, 2);
    if (wiggle) D_in = 8'($urandom);
    while (!Stop && edges < 300) begin
      @(posedge Clk); #1;
      edges++;
      j = (edges - 1 > d) ? d : edges - 1;
      check("trace_r", R, falling(d, j));
      check("trace_n", N, d - j);
    end
    check("latency", edges, d + 2);
    check("result", R, falling(d, d));
    check("stop", Stop, 1);
    repeat (2) begin
      @(posedge Clk); #1;
      check("hold_stop", Stop, 1);
      check("hold_r", R, falling(d, d));
    end
    Start = 1'b0;
    @(posedge Clk); #1;
    check("idle_state", State, 0);
    check("idle_stop", Stop, 0);
  endtask

  initial begin
    Rst_n = 1'b0;
    Start = 1'b0;
    D_in  = 8'd0;
    #12;
    check("rst_state", State, 0);
    check("rst_r", R, 0);
    check("rst_n", N, 0);
    check("rst_stop", Stop, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    check("post_rst_idle", State, 0);

    run(8, 1'b0);
    run(0, 1'b0);
    run(1, 1'b0);
    run(5, 1'b1);
    run(9, 1'b0);
    run(4, 1'b0);
    for (int k = 0; k < 12; k++) begin
      run($urandom_range(0, 12), 1'($urandom));
    end

    // asynchronous reset in the middle of MULT
    Start = 1'b1;
    D_in  = 8'd8;
    repeat (4) @(posedge Clk);
    #1;
    check("pre_abort_state", State, 2);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("abort_state", State, 0);
    check("abort_r", R, 0);
    check("abort_n", N, 0);
    check("abort_stop", Stop, 0);
    Start = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    check("abort_idle", State, 0);
    check("abort_stop2", Stop, 0);
    run(3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
